// File: rtl/y_line_window_pkg.sv
// Shared constants and types for the luma 3-line window block.
package y_line_window_pkg;

   localparam int DATA_W_DEF     = 8;
   localparam int MAX_LINE_W_DEF = 1024;
   localparam int COL_W_DEF      = $clog2(MAX_LINE_W_DEF) + 1;
   localparam int LCNT_SAT       = 2;

   // Column counter width: one extra bit so col can reach MAX_LINE_W itself
   function automatic int col_w(input int max_w);
      return $clog2(max_w) + 1;
   endfunction

   // Sideband bits carried alongside the pixel through the 2-stage pipe
   typedef struct packed {
      logic dv;
      logic hs;
      logic vs;
      logic le;
      logic wv;
   } ctl_t;

endpackage

// File: rtl/y_line_window_ram.sv
// Simple dual-port line memory: one write, one registered read per cycle.
// Read-first: a read and write to the same address return the old word.
module y_line_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port and registered read port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/y_line_window.sv
// 3-line luma window: cascaded line memories give rows n-2, n-1 and n for
// the same column, with all outputs aligned exactly 2 cycles after input.
module y_line_window
   import y_line_window_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MAX_LINE_W = MAX_LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] y_i,
   input  logic              dv_i,
   input  logic              hs_i,
   input  logic              vs_i,
   input  logic              line_end_i,
   output logic [DATA_W-1:0] y_top_o,
   output logic [DATA_W-1:0] y_mid_o,
   output logic [DATA_W-1:0] y_bot_o,
   output logic              dv_o,
   output logic              hs_o,
   output logic              vs_o,
   output logic              line_end_o,
   output logic              win_valid_o,
   output logic              overflow_o
);

   localparam int COL_W = col_w(MAX_LINE_W);
   localparam int AW    = (MAX_LINE_W > 1) ? $clog2(MAX_LINE_W) : 1;

   logic              r_vs_q;
   logic [COL_W-1:0]  r_col;
   logic [1:0]        r_lcnt;
   logic              r_ovf;

   logic              w_vs_rise;
   logic              w_le;
   logic [COL_W-1:0]  w_col_cur;
   logic [1:0]        w_lcnt_cur;
   logic              w_ovf_px;
   logic              w_wr;
   logic [COL_W-1:0]  w_col_nxt;
   logic [1:0]        w_lcnt_nxt;
   logic [AW-1:0]     w_addr;
   ctl_t              w_ctl;

   ctl_t              r_ctl_d1;
   ctl_t              r_ctl_d2;
   logic [DATA_W-1:0] r_y_d1;
   logic [AW-1:0]     r_col_d1;
   logic              r_wr_d1;
   logic              r_ovf_o;
   logic [DATA_W-1:0] r_top;
   logic [DATA_W-1:0] r_mid;
   logic [DATA_W-1:0] r_bot;

   logic [DATA_W-1:0] w_rd0;
   logic [DATA_W-1:0] w_rd1;

   // Frame/line position: vs rise clears position in the same cycle it is seen
   always_comb begin
      w_vs_rise  = vs_i & ~r_vs_q;
      w_le       = dv_i & line_end_i;
      w_col_cur  = w_vs_rise ? '0 : r_col;
      w_lcnt_cur = w_vs_rise ? '0 : r_lcnt;
      w_ovf_px   = dv_i && (w_col_cur == COL_W'(MAX_LINE_W));
      w_wr       = dv_i && !w_ovf_px;
      w_addr     = w_col_cur[AW-1:0];
      w_col_nxt  = w_col_cur;
      if (w_le)
         w_col_nxt = '0;
      else if (w_wr)
         w_col_nxt = w_col_cur + 1'b1;
      w_lcnt_nxt = w_lcnt_cur;
      if (w_le && (w_lcnt_cur < 2'(LCNT_SAT)))
         w_lcnt_nxt = w_lcnt_cur + 1'b1;
      w_ctl.dv = dv_i;
      w_ctl.hs = hs_i;
      w_ctl.vs = vs_i;
      w_ctl.le = w_le;
      w_ctl.wv = dv_i && (w_lcnt_cur >= 2'(LCNT_SAT));
   end

   // Position state and sticky overflow; overflow only clears on frame start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vs_q <= 1'b0;
         r_col  <= '0;
         r_lcnt <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_vs_q <= vs_i;
         r_col  <= w_col_nxt;
         r_lcnt <= w_lcnt_nxt;
         r_ovf  <= w_vs_rise ? 1'b0 : (r_ovf | w_ovf_px);
      end
   end

   // Stage 1: sideband, pixel and mem1 write-back address alongside the RAM read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctl_d1 <= '0;
         r_y_d1   <= '0;
         r_col_d1 <= '0;
         r_wr_d1  <= 1'b0;
      end else begin
         r_ctl_d1 <= w_ctl;
         r_col_d1 <= w_addr;
         r_wr_d1  <= w_wr;
         if (dv_i) r_y_d1 <= y_i;
      end
   end

   // Stage 2: output registers; window rows hold while no pixel is in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctl_d2 <= '0;
         r_ovf_o  <= 1'b0;
         r_top    <= '0;
         r_mid    <= '0;
         r_bot    <= '0;
      end else begin
         r_ctl_d2 <= r_ctl_d1;
         r_ovf_o  <= r_ovf;
         if (r_ctl_d1.dv) begin
            r_top <= w_rd1;
            r_mid <= w_rd0;
            r_bot <= r_y_d1;
         end
      end
   end

   // mem0 holds line n-1; its old word is read now and pushed into mem1 next cycle
   y_line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_LINE_W), .AW(AW)) u_mem0 (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (w_addr),
      .i_wdata (y_i),
      .i_re    (dv_i),
      .i_raddr (w_addr),
      .o_rdata (w_rd0)
   );

   // mem1 holds line n-2, fed from the registered mem0 read data
   y_line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_LINE_W), .AW(AW)) u_mem1 (
      .clk     (clk),
      .i_we    (r_wr_d1),
      .i_waddr (r_col_d1),
      .i_wdata (w_rd0),
      .i_re    (dv_i),
      .i_raddr (w_addr),
      .o_rdata (w_rd1)
   );

   assign y_top_o     = r_top;
   assign y_mid_o     = r_mid;
   assign y_bot_o     = r_bot;
   assign dv_o        = r_ctl_d2.dv;
   assign hs_o        = r_ctl_d2.hs;
   assign vs_o        = r_ctl_d2.vs;
   assign line_end_o  = r_ctl_d2.le;
   assign win_valid_o = r_ctl_d2.wv & r_ctl_d2.dv;
   assign overflow_o  = r_ovf_o;

endmodule

// File: tb/tb_y_line_window.sv
// Directed bench: two instances (MAX_LINE_W 8 and 4) share one stimulus.
module tb_y_line_window;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] y_i = '0;
   logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, line_end_i = 1'b0;

   logic [7:0] top_a, mid_a, bot_a, top_b, mid_b, bot_b;
   logic dv_a, hs_a, vs_a, le_a, wv_a, ovf_a;
   logic dv_b, hs_b, vs_b, le_b, wv_b, ovf_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] top;
      logic [7:0] mid;
      logic [7:0] bot;
      logic       wv;
      logic       ovf;
   } rec_t;

   rec_t qa[$];
   rec_t qb[$];

   always #5 clk = ~clk;

   y_line_window #(.DATA_W(8), .MAX_LINE_W(8)) u_a (
      .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .line_end_i(line_end_i), .y_top_o(top_a), .y_mid_o(mid_a), .y_bot_o(bot_a),
      .dv_o(dv_a), .hs_o(hs_a), .vs_o(vs_a), .line_end_o(le_a),
      .win_valid_o(wv_a), .overflow_o(ovf_a));

   y_line_window #(.DATA_W(8), .MAX_LINE_W(4)) u_b (
      .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
      .line_end_i(line_end_i), .y_top_o(top_b), .y_mid_o(mid_b), .y_bot_o(bot_b),
      .dv_o(dv_b), .hs_o(hs_b), .vs_o(vs_b), .line_end_o(le_b),
      .win_valid_o(wv_b), .overflow_o(ovf_b));

   // Capture every output pixel away from the active edge
   always @(negedge clk) begin
      if (rst === 1'b1 && dv_a === 1'b1) qa.push_back({top_a, mid_a, bot_a, wv_a, ovf_a});
      if (rst === 1'b1 && dv_b === 1'b1) qb.push_back({top_b, mid_b, bot_b, wv_b, ovf_b});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic px(input logic [7:0] y, input logic le);
      y_i = y; dv_i = 1'b1; line_end_i = le;
      @(posedge clk); #1;
      dv_i = 1'b0; line_end_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic line(input int l, input int n, input int base);
      for (int c = 0; c < n; c++) px(8'(base + l*16 + c), c == n-1);
      idle(2);
   endtask

   // Frame start pulse; also checks the 2-cycle sideband alignment
   task automatic vsp();
      vs_i = 1'b1; hs_i = 1'b1;
      @(posedge clk); #1;
      chk("vs_o_lat1", {30'd0, vs_a, hs_a}, 32'd0);
      vs_i = 1'b0; hs_i = 1'b0;
      @(posedge clk); #1;
      chk("vs_o_lat2", {30'd0, vs_a, hs_a}, 32'd3);
      idle(1);
   endtask

   function automatic int wv_cnt_a(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (i < qa.size()) n += int'(qa[i].wv);
      return n;
   endfunction

   initial begin
      rst = 1'b0;
      idle(3);
      chk("rst_outs_a", {top_a, mid_a, bot_a, dv_a, hs_a, vs_a, le_a, wv_a, ovf_a}, 32'd0);
      chk("rst_outs_b", {top_b, mid_b, bot_b, dv_b, hs_b, vs_b, le_b, wv_b, ovf_b}, 32'd0);
      rst = 1'b1;
      idle(2);

      // Warm-up and window check
      line(0, 4, 0); line(1, 4, 0); idle(2);
      chk("warm_dv_count", qa.size(), 8);
      chk("warm_wv", wv_cnt_a(0, 7), 0);
      line(2, 4, 0); idle(2);
      chk("win_size", qa.size(), 12);
      chk("win_top", qa[9].top, 8'h01);
      chk("win_mid", qa[9].mid, 8'h11);
      chk("win_bot", qa[9].bot, 8'h21);
      chk("win_valid", wv_cnt_a(8, 11), 4);

      // Blanking mid-line: outputs hold, column resumes, latency stays 2
      px(8'h30, 1'b0); px(8'h31, 1'b0);
      idle(10);
      chk("blank_hold", {8'h0, top_a, mid_a, bot_a}, {8'h0, 8'h11, 8'h21, 8'h31});
      px(8'h32, 1'b0);
      chk("blank_lat1", {dv_a, bot_a}, {1'b0, 8'h31});
      @(posedge clk); #1;
      chk("blank_lat2", {dv_a, wv_a, top_a, mid_a, bot_a}, {1'b1, 1'b1, 8'h12, 8'h22, 8'h32});
      px(8'h33, 1'b1); idle(3);

      // New frame: warm-up repeats, top row comes from the new frame
      vsp();
      qa.delete(); qb.delete();
      line(0, 4, 0); line(1, 4, 0); line(2, 4, 0); idle(2);
      chk("nf_size", qa.size(), 12);
      chk("nf_warm_wv", wv_cnt_a(0, 7), 0);
      chk("nf_wv", wv_cnt_a(8, 11), 4);
      chk("nf_top", qa[9].top, 8'h01);

      // Overflow on the MAX_LINE_W=4 instance
      vsp();
      qa.delete(); qb.delete();
      line(0, 6, 8'hA0); idle(2);
      chk("ovf_size", qb.size(), 6);
      chk("ovf_px4", {qb[3].ovf, qb[4].ovf, qb[5].ovf}, 3'b011);
      chk("ovf_a_clear", ovf_a, 1'b0);
      line(0, 4, 8'hB0); idle(2);
      chk("ovf_mem_c0", qb[6].mid, 8'hA0);
      chk("ovf_mem_c3", qb[9].mid, 8'hA3);
      chk("ovf_sticky", ovf_b, 1'b1);
      vsp();
      chk("ovf_vs_clear", ovf_b, 1'b0);

      // Reset mid-line during line 2 col 2
      vsp();
      line(0, 4, 0); line(1, 4, 0);
      px(8'h20, 1'b0); px(8'h21, 1'b0);
      y_i = 8'h22; dv_i = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0; #1;
      chk("rstmid_outs", {top_a, mid_a, bot_a, dv_a, hs_a, vs_a, le_a, wv_a, ovf_a}, 32'd0);
      dv_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      qa.delete(); qb.delete();
      line(0, 4, 0); line(1, 4, 0); line(2, 4, 0); idle(2);
      chk("rstmid_size", qa.size(), 12);
      chk("rstmid_warm", wv_cnt_a(0, 7), 0);
      chk("rstmid_first", {qa[7].wv, qa[8].wv}, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
